adder_operand_loader: RTL and testbench

ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

---
 rtl/adder_pkg.sv | 35 +++
 rtl/adder_operand_loader_if.sv | 50 +++++
 rtl/adder_operand_loader.sv | 140 ++++++++++++++
 tb/tb_adder_operand_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Purpose:
//   Shared definitions for the adder operand loader. It holds the loader FSM
//   state type and the helpers that derive the chunk count and the chunk
//   counter width from the operand and bus widths.
//
// Contents:
//   loader_state_e  LOAD_A / LOAD_B / PRESENT
//   nchunk_f        ceil(adder_width / chunk_width)
//   cnt_width_f     bits needed to index nchunk chunks (never below 1)
// -----------------------------------------------------------------------------
package adder_pkg;

  // The loader first fills operand A, then operand B, then presents the pair.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } loader_state_e;

  // Number of bus chunks needed to cover one operand. The last chunk may be
  // only partly used.
  function automatic int nchunk_f(input int adder_width, input int chunk_width);
    return (adder_width + chunk_width - 1) / chunk_width;
  endfunction

  // Width of a counter that indexes chunks 0..nchunk-1. A single-chunk
  // operand still gets a 1-bit counter so the vector is never zero-width.
  function automatic int cnt_width_f(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/adder_operand_loader_if.sv
// -----------------------------------------------------------------------------
// adder_operand_loader_if
//
// Purpose:
//   Groups the narrow chunk input handshake and the wide operand output
//   handshake of the adder operand loader.
//
// Signals:
//   in_valid / in_ready / in_data   chunk stream, least-significant chunk first
//   op_valid / op_ready             operand pair handshake to the adder stage
//   op_a / op_b                     assembled operands
//
// Modports:
//   slave   the loader itself (consumes chunks, produces operands)
//   master  the environment (supplies chunks, consumes operands)
// -----------------------------------------------------------------------------
interface adder_operand_loader_if #(
  parameter int ADDER_WIDTH = 91,
  parameter int CHUNK_WIDTH = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [CHUNK_WIDTH-1:0] in_data;
  logic                   op_valid;
  logic                   op_ready;
  logic [ADDER_WIDTH-1:0] op_a;
  logic [ADDER_WIDTH-1:0] op_b;

  modport slave (
    input  in_valid,
    input  in_data,
    input  op_ready,
    output in_ready,
    output op_valid,
    output op_a,
    output op_b
  );

  modport master (
    output in_valid,
    output in_data,
    output op_ready,
    input  in_ready,
    input  op_valid,
    input  op_a,
    input  op_b
  );

endinterface

// File: rtl/adder_operand_loader.sv
// -----------------------------------------------------------------------------
// adder_operand_loader
//
// Purpose:
//   Assembles two ADDER_WIDTH-bit operands from a CHUNK_WIDTH-bit input bus,
//   least-significant chunk first, operand A before operand B, and then holds
//   the pair on registered outputs until the downstream adder stage takes it.
//   Loading and presenting never overlap.
//
// Parameters:
//   ADDER_WIDTH  width of each assembled operand (default 91)
//   CHUNK_WIDTH  width of the input bus (default 16)
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   in_abort  (only with ADDER_LOADER_ABORT_EN) drops a partial load
//   bus       adder_operand_loader_if.slave:
//               in_valid/in_ready/in_data   chunk input handshake
//               op_valid/op_ready/op_a/op_b operand output handshake
//
// Configuration:
//   ADDER_LOADER_ABORT_EN  when defined, adds the in_abort input. An abort in
//                          LOAD_A or LOAD_B restarts loading at chunk 0 of
//                          operand A and drops any chunk offered that cycle;
//                          it has no effect in PRESENT.
// -----------------------------------------------------------------------------
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int ADDER_WIDTH = 91,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef ADDER_LOADER_ABORT_EN
  input  logic                   in_abort,
`endif
  adder_operand_loader_if.slave  bus
);

  localparam int NCHUNK = nchunk_f(ADDER_WIDTH, CHUNK_WIDTH);
  localparam int CNT_W  = cnt_width_f(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  loader_state_e          state;
  logic [CNT_W-1:0]       cnt;
  logic                   op_valid_q;
  logic [ADDER_WIDTH-1:0] op_a_q;
  logic [ADDER_WIDTH-1:0] op_b_q;

  logic                   loading;
  logic                   xfer;
  logic                   abort_req;
  logic                   last_chunk;
  logic [31:0]            shamt;
  logic [ADDER_WIDTH-1:0] chunk_data;
  logic [ADDER_WIDTH-1:0] chunk_mask;

  // The abort request only exists in the abort-enabled build; otherwise it is
  // tied off so the FSM below is the same in both builds.
`ifdef ADDER_LOADER_ABORT_EN
  assign abort_req = in_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Ready is decoded straight from the state, so a chunk can be taken on the
  // first cycle after reset and on the cycle after the pair is consumed.
  assign loading       = (state == LOAD_A) || (state == LOAD_B);
  assign bus.in_ready  = loading;
  assign xfer          = bus.in_valid && loading;
  assign last_chunk    = (cnt == LAST_IDX);

  // Place the incoming chunk at its slot in the operand. The shift happens at
  // operand width, so bits of the last chunk that land at or above
  // ADDER_WIDTH fall off the top and are never stored.
  always_comb begin
    shamt      = 32'(cnt) * 32'(CHUNK_WIDTH);
    chunk_data = ADDER_WIDTH'(bus.in_data) << shamt;
    chunk_mask = ADDER_WIDTH'({CHUNK_WIDTH{1'b1}}) << shamt;
  end

  // Loader FSM. Operand registers are only written on an accepted chunk while
  // loading, which keeps them stable for the whole time the pair is
  // presented. They are never cleared between pairs because every valid bit
  // is rewritten by the next load. op_valid is registered alongside the state
  // so it is high exactly while the state is PRESENT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      cnt        <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (abort_req) begin
            state <= LOAD_A;
            cnt   <= '0;
          end else if (xfer) begin
            if (state == LOAD_A) begin
              op_a_q <= (op_a_q & ~chunk_mask) | chunk_data;
            end else begin
              op_b_q <= (op_b_q & ~chunk_mask) | chunk_data;
            end
            if (last_chunk) begin
              cnt <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state      <= PRESENT;
                op_valid_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        PRESENT: begin
          if (bus.op_ready) begin
            state      <= LOAD_A;
            op_valid_q <= 1'b0;
          end
        end
        default: begin
          state      <= LOAD_A;
          cnt        <= '0;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_adder_operand_loader
//
// Purpose:
//   Self-checking bench for adder_operand_loader at default widths. Expected
//   operands come from a reference model that sums chunk * 2^(16k) and
//   reduces modulo 2^91. Covers reset, directed and random loads with and
//   without gaps, the partial last chunk, long holds in PRESENT, and reset in
//   the middle of a load and while presenting. With ADDER_LOADER_ABORT_EN
//   defined it also covers abort during loading and abort while presenting.
// -----------------------------------------------------------------------------
module tb_adder_operand_loader;

  localparam int AW  = 91;
  localparam int CW  = 16;
  localparam int NCH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef ADDER_LOADER_ABORT_EN
  logic in_abort = 1'b0;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  adder_operand_loader_if #(.ADDER_WIDTH(AW), .CHUNK_WIDTH(CW)) bus ();

  adder_operand_loader #(.ADDER_WIDTH(AW), .CHUNK_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ADDER_LOADER_ABORT_EN
    .in_abort (in_abort),
`endif
    .bus      (bus)
  );

  // Counts every comparison and reports any mismatch on one line.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: an operand is the sum of its chunks weighted by
  // 2^(16k), taken modulo 2^91.
  function automatic logic [AW-1:0] assemble(input logic [15:0] ch [NCH]);
    logic [127:0] acc;
    acc = '0;
    for (int k = 0; k < NCH; k++) acc = acc + (128'(ch[k]) << (CW * k));
    return acc[AW-1:0];
  endfunction

  // Offers one chunk, optionally after a few idle cycles, and returns #1
  // after the edge on which it was accepted.
  task automatic sendChunk(input logic [15:0] d, input bit gaps);
    int waitCycles;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.op_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.op_ready = 1'($urandom);
    waitCycles = 0;
    while (!bus.in_ready && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!bus.in_ready) checkOutput("ready_timeout", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b0;
  endtask

  // Loads a full pair and checks op_valid stays low until the cycle right
  // after the final transfer.
  task automatic applyStimulus(input logic [15:0] a [NCH], input logic [15:0] b [NCH],
                               input bit gaps);
    for (int i = 0; i < 2 * NCH; i++) begin
      sendChunk((i < NCH) ? a[i] : b[i - NCH], gaps);
      if (i == 2 * NCH - 2) checkOutput("valid_early", 128'(bus.op_valid), 128'(0));
    end
    checkOutput("valid_latency", 128'(bus.op_valid), 128'(1));
    checkOutput("ready_present", 128'(bus.in_ready), 128'(0));
  endtask

  task automatic checkPair(input string tag, input logic [AW-1:0] expA,
                           input logic [AW-1:0] expB);
    checkOutput({tag, "_op_a"}, 128'(bus.op_a), 128'(expA));
    checkOutput({tag, "_op_b"}, 128'(bus.op_b), 128'(expB));
  endtask

  // Consumes the presented pair and confirms loading may resume next cycle.
  task automatic consumePair();
    bus.op_ready = 1'b1;
    @(posedge clk); #1;
    bus.op_ready = 1'b0;
    checkOutput("released_valid", 128'(bus.op_valid), 128'(0));
    checkOutput("released_ready", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic randomChunks(output logic [15:0] ch [NCH]);
    for (int k = 0; k < NCH; k++) ch[k] = 16'($urandom);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] a [NCH];
    logic [15:0] b [NCH];
    logic [AW-1:0] expA;
    logic [AW-1:0] expB;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.op_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 128'(bus.op_valid), 128'(0));
    checkOutput("reset_op_a", 128'(bus.op_a), 128'(0));
    checkOutput("reset_op_b", 128'(bus.op_b), 128'(0));
    checkOutput("reset_ready", 128'(bus.in_ready), 128'(1));
    rst_n = 1'b1;

    // Directed back-to-back load
    a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    b = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    applyStimulus(a, b, 1'b0);
    checkOutput("directed_op_a", 128'(bus.op_a), 128'(91'h666_5555_4444_3333_2222_1111));
    checkOutput("directed_op_b", 128'(bus.op_b), 128'(91'h006_0005_0004_0003_0002_0001));

    // Hold in PRESENT with chunks offered; nothing may move
    expA = assemble(a);
    expB = assemble(b);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", 128'(bus.op_valid), 128'(1));
      checkOutput("hold_ready", 128'(bus.in_ready), 128'(0));
      checkPair("hold", expA, expB);
    end
    bus.in_valid = 1'b0;
    consumePair();

    // Partial last chunk: upper bits of 0xFFFF are dropped
    randomChunks(a);
    randomChunks(b);
    a[NCH-1] = 16'hFFFF;
    applyStimulus(a, b, 1'b0);
    checkOutput("top_bits", 128'(bus.op_a[90:80]), 128'(11'h7FF));
    checkPair("last_chunk", assemble(a), assemble(b));
    checkOutput("no_x", 128'({$isunknown(bus.op_a), $isunknown(bus.op_b),
                              $isunknown(bus.op_valid), $isunknown(bus.in_ready)}), 128'(0));
    consumePair();

    // Random data, each pair loaded with gaps and then without
    for (int t = 0; t < 6; t++) begin
      randomChunks(a);
      randomChunks(b);
      applyStimulus(a, b, 1'b1);
      checkPair("gapped", assemble(a), assemble(b));
      consumePair();
      applyStimulus(a, b, 1'b0);
      checkPair("gapfree", assemble(a), assemble(b));
      consumePair();
    end

    // Reset after the 7th chunk discards the partial pair
    randomChunks(a);
    for (int i = 0; i < NCH; i++) sendChunk(a[i], 1'b0);
    sendChunk(16'($urandom), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midload_valid", 128'(bus.op_valid), 128'(0));
    checkPair("midload", '0, '0);
    checkOutput("midload_ready", 128'(bus.in_ready), 128'(1));
    randomChunks(a);
    randomChunks(b);
    applyStimulus(a, b, 1'b0);
    checkPair("after_reset", assemble(a), assemble(b));

    // Reset while presenting drops the pair without a handshake
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("present_reset_valid", 128'(bus.op_valid), 128'(0));
    checkPair("present_reset", '0, '0);

`ifdef ADDER_LOADER_ABORT_EN
    // Abort after 3 chunks with a chunk offered in the same cycle
    for (int i = 0; i < 3; i++) sendChunk(16'($urandom), 1'b0);
    in_abort     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    @(posedge clk); #1;
    in_abort     = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("abort_ready", 128'(bus.in_ready), 128'(1));
    checkOutput("abort_valid", 128'(bus.op_valid), 128'(0));
    randomChunks(a);
    randomChunks(b);
    applyStimulus(a, b, 1'b0);
    checkPair("after_abort", assemble(a), assemble(b));

    // Abort is ignored while presenting
    in_abort = 1'b1;
    @(posedge clk); #1;
    in_abort = 1'b0;
    checkOutput("abort_present_valid", 128'(bus.op_valid), 128'(1));
    checkPair("abort_present", assemble(a), assemble(b));
    consumePair();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
